// File: rtl/psram_arbiter.sv
// Two-channel PSRAM command arbiter: HDMI reader (ch0, priority) and CPU bridge (ch1),
// with minimum command spacing and bounded ch0 streak while ch1 waits.
module psram_arbiter #(
    parameter int unsigned TCMD_cyc       = 18,
    parameter int unsigned BURST_BEATS    = 16,
    parameter int unsigned CH0_MAX_STREAK = 4
) (
    input  logic        psramclk,
    input  logic        rst,
    input  logic        ch0_cmd_en,
    input  logic [20:0] ch0_addr,
    output logic        ch0_cmd_ready,
    output logic        ch0_rvalid,
    input  logic        ch1_cmd_en,
    input  logic        ch1_cmd,
    input  logic [20:0] ch1_addr,
    input  logic [31:0] ch1_wdata,
    output logic        ch1_cmd_ready,
    output logic        ch1_wnext,
    output logic        ch1_rvalid,
    output logic [31:0] psram_rdata_o,
    output logic        psram_cmd,
    output logic        psram_cmd_en,
    output logic [20:0] psram_addr,
    output logic [31:0] psram_wdata,
    input  logic [31:0] psram_rdata,
    input  logic        psram_rvalid,
    input  logic        psram_cmd_ready,
    output logic        arb_err
);

    localparam int unsigned SpW   = (TCMD_cyc > 1) ? $clog2(TCMD_cyc) : 1;
    localparam int unsigned BeatW = $clog2(BURST_BEATS + 1);
    localparam int unsigned StrW  = $clog2(CH0_MAX_STREAK + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StRdata, StWdata, StGap} state_e;

    state_e           state_q, state_d;
    logic             grant_q, cmd_q;
    logic [20:0]      addr_q;
    logic [SpW-1:0]   spacing_q, spacing_d;
    logic [BeatW-1:0] beat_q;
    logic [StrW-1:0]  streak_q;
    logic             sel, can_accept, acc0, acc1, accept, last_beat;

    assign sel        = ch1_cmd_en & (~ch0_cmd_en | (streak_q == StrW'(CH0_MAX_STREAK)));
    assign can_accept = (state_q == StIdle) & psram_cmd_ready & ~rst;
    assign acc0       = ch0_cmd_en & can_accept & ~sel;
    assign acc1       = ch1_cmd_en & can_accept & sel;
    assign accept     = acc0 | acc1;
    assign last_beat  = (beat_q == BeatW'(BURST_BEATS - 1));

    assign psram_rdata_o = psram_rdata;

    // Spacing is counted from the accept edge so the next accept lands exactly TCMD_cyc later.
    always_comb begin
        spacing_d = '0;
        if (accept) begin
            spacing_d = SpW'(TCMD_cyc - 1);
        end else if (spacing_q != '0) begin
            spacing_d = spacing_q - 1'b1;
        end
    end

    always_ff @(posedge psramclk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: begin
                if (cmd_q) begin
                    state_d = (BURST_BEATS == 1) ? StGap : StWdata;
                end else begin
                    state_d = StRdata;
                end
            end
            StRdata: if (psram_rvalid && last_beat) state_d = StGap;
            StWdata: if (last_beat) state_d = StGap;
            StGap:   if (spacing_d == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge psramclk) begin
        if (rst) begin
            grant_q   <= 1'b0;
            cmd_q     <= 1'b0;
            addr_q    <= '0;
            spacing_q <= '0;
            beat_q    <= '0;
            streak_q  <= '0;
            arb_err   <= 1'b0;
        end else begin
            spacing_q <= spacing_d;
            if (accept) begin
                grant_q <= acc1;
                cmd_q   <= acc1 & ch1_cmd;
                addr_q  <= acc1 ? ch1_addr : ch0_addr;
            end
            if (~ch1_cmd_en | acc1) begin
                streak_q <= '0;
            end else if (acc0 && streak_q != StrW'(CH0_MAX_STREAK)) begin
                streak_q <= streak_q + 1'b1;
            end
            // Write beat 0 goes out with the command, so the write count starts at 1.
            case (state_q)
                StIssue: beat_q <= cmd_q ? BeatW'(1) : '0;
                StRdata: if (psram_rvalid) beat_q <= beat_q + 1'b1;
                StWdata: beat_q <= beat_q + 1'b1;
                default: beat_q <= '0;
            endcase
            if (psram_rvalid && state_q != StRdata) begin
                arb_err <= 1'b1;
            end
        end
    end

    always_comb begin
        ch0_cmd_ready = can_accept & ~sel;
        ch1_cmd_ready = can_accept & sel;
        psram_cmd_en  = 1'b0;
        psram_cmd     = 1'b0;
        psram_addr    = '0;
        ch1_wnext     = 1'b0;
        ch0_rvalid    = 1'b0;
        ch1_rvalid    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIssue: begin
                    psram_cmd_en = 1'b1;
                    psram_cmd    = cmd_q;
                    psram_addr   = addr_q;
                    ch1_wnext    = cmd_q;
                end
                StRdata: begin
                    ch0_rvalid = psram_rvalid & ~grant_q;
                    ch1_rvalid = psram_rvalid & grant_q;
                end
                StWdata: ch1_wnext = 1'b1;
                default: ;
            endcase
        end
        psram_wdata = ch1_wnext ? ch1_wdata : '0;
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Randomized bench for psram_arbiter: a transaction-level model predicts grants, command timing,
// write beats and read forwarding each cycle; directed phases cover the listed scenarios.
module tb_psram_arbiter;

    localparam int TCMD   = 18;
    localparam int BURST  = 16;
    localparam int MAXS   = 4;
    localparam int WR_GAP = (TCMD > BURST + 2) ? TCMD : BURST + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        ch0_cmd_en = 1'b0, ch1_cmd_en = 1'b0, ch1_cmd = 1'b0;
    logic [20:0] ch0_addr = '0, ch1_addr = '0;
    logic [31:0] ch1_wdata = '0, psram_rdata = '0;
    logic        psram_rvalid = 1'b0, psram_cmd_ready = 1'b1;
    logic        ch0_cmd_ready, ch0_rvalid, ch1_cmd_ready, ch1_wnext, ch1_rvalid;
    logic [31:0] psram_rdata_o, psram_wdata;
    logic        psram_cmd, psram_cmd_en, arb_err;
    logic [20:0] psram_addr;

    psram_arbiter #(.TCMD_cyc(TCMD), .BURST_BEATS(BURST), .CH0_MAX_STREAK(MAXS)) dut (
        .psramclk(clk), .rst(rst),
        .ch0_cmd_en(ch0_cmd_en), .ch0_addr(ch0_addr), .ch0_cmd_ready(ch0_cmd_ready),
        .ch0_rvalid(ch0_rvalid),
        .ch1_cmd_en(ch1_cmd_en), .ch1_cmd(ch1_cmd), .ch1_addr(ch1_addr), .ch1_wdata(ch1_wdata),
        .ch1_cmd_ready(ch1_cmd_ready), .ch1_wnext(ch1_wnext), .ch1_rvalid(ch1_rvalid),
        .psram_rdata_o(psram_rdata_o), .psram_cmd(psram_cmd), .psram_cmd_en(psram_cmd_en),
        .psram_addr(psram_addr), .psram_wdata(psram_wdata), .psram_rdata(psram_rdata),
        .psram_rvalid(psram_rvalid), .psram_cmd_ready(psram_cmd_ready), .arb_err(arb_err)
    );

    // Second instance with single-beat bursts so that command spacing dominates.
    logic        s_rst = 1'b1, s_rvalid = 1'b0;
    logic        s_ch0_ready, s_ch0_rvalid, s_ch1_ready, s_ch1_wnext, s_ch1_rvalid;
    logic [31:0] s_rdata_o, s_wdata;
    logic        s_cmd, s_cmd_en, s_err;
    logic [20:0] s_addr;

    psram_arbiter #(.TCMD_cyc(18), .BURST_BEATS(1), .CH0_MAX_STREAK(4)) dut_sp (
        .psramclk(clk), .rst(s_rst),
        .ch0_cmd_en(1'b1), .ch0_addr(21'h000040), .ch0_cmd_ready(s_ch0_ready),
        .ch0_rvalid(s_ch0_rvalid),
        .ch1_cmd_en(1'b0), .ch1_cmd(1'b0), .ch1_addr(21'h0), .ch1_wdata(32'h0),
        .ch1_cmd_ready(s_ch1_ready), .ch1_wnext(s_ch1_wnext), .ch1_rvalid(s_ch1_rvalid),
        .psram_rdata_o(s_rdata_o), .psram_cmd(s_cmd), .psram_cmd_en(s_cmd_en),
        .psram_addr(s_addr), .psram_wdata(s_wdata), .psram_rdata(32'h0),
        .psram_rvalid(s_rvalid), .psram_cmd_ready(1'b1), .arb_err(s_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          cyc = 0, earliest = 0, acc_cyc = -1000, rd_seen = 0, m_streak = 0;
    bit          reading = 0, cur_wr = 0, cur_ch = 0, err_m = 0;
    logic [20:0] cur_addr = '0;

    // Stimulus state
    bit          rst_req = 1, req_rand = 0, req_both = 0, rdy_hold0 = 0;
    bit          dir0 = 0, dir1 = 0, dir1_cmd = 0;
    logic [20:0] dir0_addr = '0, dir1_addr = '0;
    int          rdy_pct = 100, ctl_left = 0, ctl_delay = 0, wcount = 0;
    logic [31:0] wbase = 32'h1000_0000, last_wd = '0;
    bit          acc0_prev = 0, acc1_prev = 0;
    int          n_r0 = 0, n_r1 = 0, n_wn = 0, n_cmd = 0, n_rdy = 0;
    bit          grants[$];

    task automatic step();
        bit a0, a1, can, exp_ch, exp_wn, fwd;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_req;
        if (acc0_prev) ch0_cmd_en = 1'b0;
        if (acc1_prev) ch1_cmd_en = 1'b0;
        if (dir0) begin ch0_cmd_en = 1'b1; ch0_addr = dir0_addr; dir0 = 0; end
        if (dir1) begin ch1_cmd_en = 1'b1; ch1_cmd = dir1_cmd; ch1_addr = dir1_addr; dir1 = 0; end
        if ((req_rand && $urandom_range(0, 3) == 0) || req_both) begin
            if (!ch0_cmd_en) begin ch0_cmd_en = 1'b1; ch0_addr = 21'($urandom); end
        end
        if ((req_rand && $urandom_range(0, 3) == 0) || req_both) begin
            if (!ch1_cmd_en) begin
                ch1_cmd_en = 1'b1;
                ch1_cmd    = 1'($urandom_range(0, 1));
                ch1_addr   = 21'($urandom);
            end
        end
        ch1_wdata       = wbase + 32'(wcount);
        psram_cmd_ready = rdy_hold0 ? 1'b0 : (int'($urandom_range(0, 99)) < rdy_pct);
        psram_rdata     = $urandom;
        psram_rvalid    = 1'b0;
        if (ctl_left > 0) begin
            if (ctl_delay > 0) ctl_delay--;
            else if ($urandom_range(0, 2) != 0) begin psram_rvalid = 1'b1; ctl_left--; end
        end

        @(negedge clk);
        a0 = ch0_cmd_en & ch0_cmd_ready;
        a1 = ch1_cmd_en & ch1_cmd_ready;
        n_cmd += int'(psram_cmd_en);
        n_rdy += int'(ch0_cmd_ready | ch1_cmd_ready);
        n_r0  += int'(ch0_rvalid);
        n_r1  += int'(ch1_rvalid);
        n_wn  += int'(ch1_wnext);
        if (rst) begin
            check("rst_outs", {ch0_cmd_ready, ch1_cmd_ready, ch0_rvalid, ch1_rvalid, ch1_wnext,
                               psram_cmd, psram_cmd_en, psram_addr, psram_wdata}, '0);
        end
        check("ready_excl", ch0_cmd_ready & ch1_cmd_ready, 0);
        can    = !rst && cyc >= earliest && psram_cmd_ready && (ch0_cmd_en || ch1_cmd_en);
        exp_ch = ch1_cmd_en && (!ch0_cmd_en || m_streak == MAXS);
        check("accept", {a1, a0}, can ? (exp_ch ? 2 : 1) : 0);
        check("cmd_en", psram_cmd_en, !rst && cyc == acc_cyc + 1);
        if (!rst && cyc == acc_cyc + 1) begin
            check("cmd_addr", psram_addr, cur_addr);
            check("cmd_type", psram_cmd, cur_wr);
            if (!cur_wr) begin ctl_left = BURST; ctl_delay = $urandom_range(1, 4); end
        end
        exp_wn = !rst && cur_wr && cyc >= acc_cyc + 1 && cyc <= acc_cyc + BURST;
        check("wnext", ch1_wnext, exp_wn);
        if (exp_wn) check("wdata", psram_wdata, wbase + 32'(cyc - acc_cyc - 1));
        if (ch1_wnext) begin wcount++; last_wd = psram_wdata; end
        fwd = !rst && reading && psram_rvalid;
        check("ch0_rvalid", ch0_rvalid, fwd && !cur_ch);
        check("ch1_rvalid", ch1_rvalid, fwd && cur_ch);
        check("rdata_o", psram_rdata_o, psram_rdata);
        check("arb_err", arb_err, err_m);

        if (rst) begin
            earliest = cyc + 1; acc_cyc = -1000; reading = 0; cur_wr = 0;
            m_streak = 0; err_m = 0;
        end else begin
            if (psram_rvalid && !reading) err_m = 1;
            if (fwd) begin
                rd_seen++;
                if (rd_seen == BURST) begin
                    reading  = 0;
                    earliest = (acc_cyc + TCMD > cyc + 2) ? acc_cyc + TCMD : cyc + 2;
                end
            end
            if (a1) m_streak = 0;
            else if (a0 && ch1_cmd_en && m_streak < MAXS) m_streak++;
            if (!ch1_cmd_en) m_streak = 0;
            if (a0 || a1) begin
                acc_cyc  = cyc;
                cur_ch   = a1;
                cur_wr   = a1 && ch1_cmd;
                cur_addr = a1 ? ch1_addr : ch0_addr;
                reading  = !cur_wr;
                rd_seen  = 0;
                earliest = cur_wr ? cyc + WR_GAP : cyc + 1_000_000;
                if (cur_wr) begin
                    wcount = 0;
                    if (req_rand) wbase = $urandom;
                end
                grants.push_back(a1);
            end
        end
        acc0_prev = a0;
        acc1_prev = a1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && (ch0_cmd_en || ch1_cmd_en || dir0 || dir1 || reading ||
                                 ctl_left > 0 || cyc < earliest); i++) step();
        check("drain_done", i < 3000, 1);
    endtask

    task automatic reset_pulse();
        rst_req = 1;
        step();
        rst_req = 0;
    endtask

    initial begin
        int s0, s1, s2, n;
        int pulses[$];
        int last_cmd;
        step();
        step();
        rst_req = 0;

        // Single ch0 read
        dir0 = 1; dir0_addr = 21'h000100;
        s0 = n_r0; s1 = n_r1; s2 = n_cmd;
        drain();
        check("rd_beats", n_r0 - s0, BURST);
        check("rd_ch1_quiet", n_r1 - s1, 0);
        check("rd_cmds", n_cmd - s2, 1);

        // ch1 write burst 0x1000_0000..0x1000_000F
        wbase = 32'h1000_0000;
        dir1 = 1; dir1_cmd = 1; dir1_addr = 21'h0abcde;
        s0 = n_wn;
        drain();
        check("wr_beats", n_wn - s0, BURST);
        check("wr_last", last_wd, 32'h1000_000F);

        // Controller not ready, then starvation order
        reset_pulse();
        grants.delete();
        rdy_hold0 = 1; req_both = 1;
        s0 = n_cmd; s1 = n_rdy;
        repeat (100) step();
        check("nr_cmd", n_cmd - s0, 0);
        check("nr_ready", n_rdy - s1, 0);
        rdy_hold0 = 0;
        step();
        check("nr_release_grant", {acc1_prev, acc0_prev}, 2'b01);
        for (n = 0; n < 1000 && grants.size() < 10; n++) step();
        check("starv_count", grants.size() >= 10, 1);
        for (int i = 0; i < 10 && i < grants.size(); i++) begin
            check("starv_order", grants[i], (i % 5) == 4);
        end
        req_both = 0;
        drain();

        // Random traffic
        s0 = n_cmd;
        req_rand = 1; rdy_pct = 85;
        repeat (3000) step();
        req_rand = 0; rdy_pct = 100;
        drain();
        check("rand_activity", (n_cmd - s0) > 20, 1);

        // Reset in the middle of a read burst
        reset_pulse();
        dir0 = 1; dir0_addr = 21'h012345;
        for (n = 0; n < 300 && !(reading && rd_seen == 7); n++) step();
        check("mr_beat7", rd_seen, 7);
        s0 = n_r0 + n_r1;
        reset_pulse();
        for (n = 0; n < 300 && ctl_left > 0; n++) step();
        step();
        check("mr_err", arb_err, 1);
        check("mr_fwd", n_r0 + n_r1 - s0, 0);
        check("mr_ready_after", ch0_cmd_ready, 1);

        // Command spacing with single-beat reads
        last_cmd = -100;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            s_rst    = (i < 2);
            s_rvalid = (i == last_cmd + 2);
            @(negedge clk);
            if (s_cmd_en) begin pulses.push_back(i); last_cmd = i; end
        end
        check("sp_count", pulses.size() >= 5, 1);
        for (int k = 1; k < 5 && k < pulses.size(); k++) begin
            check("sp_gap", pulses[k] - pulses[k-1], 18);
        end
        check("sp_err", s_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1);
    end

endmodule
